// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// FSM encodings and counter sizing helper.
package serial_ripple_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_ripple_subtractor_cell.sv
// One-bit full subtractor used as the single
// time-shared cell of the serial subtractor.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin,
// one bit per clock, LSB first, start/done handshake.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  import serial_ripple_subtractor_pkg::*;

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    count;
  logic             br;
  logic             d;
  logic             bo;
  logic             last;
  logic             accept;

  assign last   = (count == LAST);
  assign accept = (state == IDLE) && start;

  full_sub_cell u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (br),
    .d   (d),
    .bo  (bo)
  );

  // New difference bit enters at the MSB so the
  // result lines up after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = d;
    end else begin : g_resn
      assign res_nxt = {d, res_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    busy = 1'b0;
    unique case (1'b1)
      (state == RUN):  busy = 1'b1;
      (state == DONE): begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      br    <= bin;
      count <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      br     <= bo;
      count  <= count + 1'b1;
      if (last) begin
        diff <= res_nxt;
        bout <= bo;
      end
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and exhaustive checks of the serial subtractor
// at WIDTH=4, plus WIDTH=1 and WIDTH=16 instances.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic       start, bin, busy, done, bout;
  logic [3:0] a, b, diff;

  logic start1, a1, b1, bin1, busy1, done1, diff1, bout1;

  logic        start16, bin16, busy16, done16, bout16;
  logic [15:0] a16, b16, diff16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done),
    .diff(diff), .bout(bout)
  );

  serial_ripple_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1),
    .diff(diff1), .bout(bout1)
  );

  serial_ripple_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16),
    .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16),
    .diff(diff16), .bout(bout16)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one WIDTH=4 op, wait for done; lat counts the
  // acceptance cycle as cycle 1.
  task automatic run4(input logic [3:0] ia,
                      input logic [3:0] ib,
                      input logic ibin,
                      output int lat,
                      output int bcnt,
                      output logic hold_ok);
    logic [3:0] pd;
    logic       pb;
    pd = diff;
    pb = bout;
    hold_ok = 1'b1;
    a = ia;
    b = ib;
    bin = ibin;
    start = 1'b1;
    step();
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
    bin = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (diff !== pd || bout !== pb) hold_ok = 1'b0;
      step();
      lat++;
    end
    if (busy) bcnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, bcnt, n, pulses;
    logic hold;
    logic [4:0] exp5;

    vt[0] = '{4'd9,  4'd5,  1'b0, 4'd4,  1'b0};
    vt[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1};
    vt[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vt[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    vt[4] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0};
    vt[5] = '{4'd8,  4'd7,  1'b1, 4'd0,  1'b0};
    vt[6] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
    vt[7] = '{4'd10, 4'd3,  1'b1, 4'd6,  1'b0};

    rst = 1'b1;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run4(vt[i].a, vt[i].b, vt[i].bin, lat, bcnt, hold);
      chk($sformatf("vec%0d_res", i), 32'({bout, diff}),
          32'({vt[i].bo, vt[i].d}));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd5);
      chk($sformatf("vec%0d_hold", i), 32'(hold), 32'd1);
      step();
      chk($sformatf("vec%0d_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end

    // Starts during RUN and DONE must be ignored.
    a = 4'd12; b = 4'd4; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 4'd1; b = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("ign_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      step();
    end
    chk("ign_pulses", 32'(pulses), 32'd0);
    chk("ign_res", 32'({bout, diff}), 32'h08);

    // Reset in the second RUN cycle discards the op.
    a = 4'd6; b = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
    run4(4'd7, 4'd2, 1'b0, lat, bcnt, hold);
    chk("post_rst_res", 32'({bout, diff}), 32'h05);
    chk("post_rst_lat", 32'(lat), 32'd5);
    step();

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          run4(4'(ia), 4'(ib), 1'(ic), lat, bcnt, hold);
          exp5 = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
          chk($sformatf("ex_%0d_%0d_%0d", ia, ib, ic),
              32'({bout, diff}), 32'(exp5));
          chk($sformatf("ex_hold_%0d_%0d_%0d", ia, ib, ic),
              32'(hold), 32'd1);
          step();
        end
      end
    end

    a1 = 1'b1; b1 = 1'b1; bin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done1 && lat < 40) begin
      if (busy1) bcnt++;
      step();
      lat++;
    end
    if (busy1) bcnt++;
    chk("w1_lat", 32'(lat), 32'd2);
    chk("w1_busy", 32'(bcnt), 32'd2);
    chk("w1_res", 32'({bout1, diff1}), 32'h3);
    step();

    a16 = 16'h0000; b16 = 16'h0001; bin16 = 1'b0;
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done16 && lat < 60) begin
      if (busy16) bcnt++;
      step();
      lat++;
    end
    if (busy16) bcnt++;
    chk("w16_lat", 32'(lat), 32'd17);
    chk("w16_busy", 32'(bcnt), 32'd17);
    chk("w16_res", 32'({bout16, diff16}), 32'h1FFFF);
    step();
    chk("w16_pulse", 32'(done16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
